shift_fu: RTL and testbench

Pipelined shift/rotate functional unit for the out-of-order 6502 core. It accepts issued ASL/LSR/ROL/ROR micro-ops from a reservation station over a valid/ready handshake and carries each op's tag through the pipeline. It computes the 8-bit result and the updated processor-status byte, then presents both on a result port with its own valid/ready handshake toward the writeback/CDB arbiter. Two register stages give full throughput under backpressure, and a flush input squashes all in-flight ops.

---
 rtl/shift_fu_if.sv | 28 ++
 rtl/shift_fu.sv | 125 ++++++++++++
 tb/tb_shift_fu.sv | 383 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/shift_fu_if.sv
// Issue and result handshake bundle for the shift/rotate unit.
// slave = the functional unit, master = the issuing/consuming side.
interface shift_fu_if #(
    parameter int TAG_W = 4
) ();
    logic             in_valid;
    logic             in_ready;
    logic [TAG_W-1:0] in_tag;
    logic [7:0]       in_a;
    logic [7:0]       in_f;
    logic             in_rotate;
    logic             in_right;
    logic             out_valid;
    logic             out_ready;
    logic [TAG_W-1:0] out_tag;
    logic [7:0]       out_q;
    logic [7:0]       out_f;

    modport slave (
        input  in_valid, in_tag, in_a, in_f, in_rotate, in_right, out_ready,
        output in_ready, out_valid, out_tag, out_q, out_f
    );

    modport master (
        output in_valid, in_tag, in_a, in_f, in_rotate, in_right, out_ready,
        input  in_ready, out_valid, out_tag, out_q, out_f
    );
endinterface

// File: rtl/shift_fu.sv
// Two-stage pipelined ASL/LSR/ROL/ROR unit for the 6502 core: S1 holds the issued op,
// S2 holds result, status and tag and drives the result port directly.
module shift_fu #(
    parameter int TAG_W = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      flush,
    shift_fu_if.slave io
);
    // Handshakes: a transfer happens on a rising edge where valid && ready are both 1.
    // in_ready never depends on in_valid; out_valid never depends on out_ready.

    logic             s1_valid_q, s1_valid_d;
    logic [TAG_W-1:0] s1_tag_q, s1_tag_d;
    logic [7:0]       s1_a_q, s1_a_d;
    logic [7:0]       s1_f_q, s1_f_d;
    logic             s1_rotate_q, s1_rotate_d;
    logic             s1_right_q, s1_right_d;

    logic             s2_valid_q, s2_valid_d;
    logic [TAG_W-1:0] s2_tag_q, s2_tag_d;
    logic [7:0]       s2_res_q, s2_res_d;
    logic [7:0]       s2_f_q, s2_f_d;

    logic             s1_adv;
    logic             in_ready_c;
    logic             accept;
    logic             retire;
    logic             cin;
    logic             cout;
    logic [7:0]       res;
    logic [7:0]       res_f;

    always_comb begin
        s1_adv     = s1_valid_q && (!s2_valid_q || io.out_ready);
        in_ready_c = !flush && (!s1_valid_q || s1_adv);
        accept     = io.in_valid && in_ready_c;
        retire     = s2_valid_q && io.out_ready;
    end

    // Shifter on the S1 operands; V/B/D/I and the unused bit pass through untouched.
    always_comb begin
        cin = s1_rotate_q ? s1_f_q[0] : 1'b0;
        if (s1_right_q) begin
            res  = {cin, s1_a_q[7:1]};
            cout = s1_a_q[0];
        end else begin
            res  = {s1_a_q[6:0], cin};
            cout = s1_a_q[7];
        end
        res_f = {res[7], s1_f_q[6:2], (res == 8'h00), cout};
    end

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_tag_d    = s1_tag_q;
        s1_a_d      = s1_a_q;
        s1_f_d      = s1_f_q;
        s1_rotate_d = s1_rotate_q;
        s1_right_d  = s1_right_q;
        s2_valid_d  = s2_valid_q;
        s2_tag_d    = s2_tag_q;
        s2_res_d    = s2_res_q;
        s2_f_d      = s2_f_q;

        if (accept) begin
            s1_valid_d  = 1'b1;
            s1_tag_d    = io.in_tag;
            s1_a_d      = io.in_a;
            s1_f_d      = io.in_f;
            s1_rotate_d = io.in_rotate;
            s1_right_d  = io.in_right;
        end else if (s1_adv) begin
            s1_valid_d = 1'b0;
        end

        if (s1_adv) begin
            s2_valid_d = 1'b1;
            s2_tag_d   = s1_tag_q;
            s2_res_d   = res;
            s2_f_d     = res_f;
        end else if (retire) begin
            s2_valid_d = 1'b0;
        end

        // Squash wins over everything; data may load but stays invisible.
        if (flush) begin
            s1_valid_d = 1'b0;
            s2_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_tag_q    <= '0;
            s1_a_q      <= '0;
            s1_f_q      <= '0;
            s1_rotate_q <= 1'b0;
            s1_right_q  <= 1'b0;
            s2_valid_q  <= 1'b0;
            s2_tag_q    <= '0;
            s2_res_q    <= '0;
            s2_f_q      <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_tag_q    <= s1_tag_d;
            s1_a_q      <= s1_a_d;
            s1_f_q      <= s1_f_d;
            s1_rotate_q <= s1_rotate_d;
            s1_right_q  <= s1_right_d;
            s2_valid_q  <= s2_valid_d;
            s2_tag_q    <= s2_tag_d;
            s2_res_q    <= s2_res_d;
            s2_f_q      <= s2_f_d;
        end
    end

    assign io.in_ready  = in_ready_c;
    assign io.out_valid = s2_valid_q;
    assign io.out_tag   = s2_tag_q;
    assign io.out_q     = s2_res_q;
    assign io.out_f     = s2_f_q;
endmodule

// File: tb/tb_shift_fu.sv
// Bench for shift_fu: directed scenario tasks plus a scoreboard fed on accepted issues
// and drained on retired results.
module tb_shift_fu;
    localparam int TAG_W = 4;
    localparam int EW    = TAG_W + 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    int   errors = 0;
    int   checks = 0;
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] mon_got;
    logic [EW-1:0] mon_exp;

    shift_fu_if #(.TAG_W(TAG_W)) bus ();

    shift_fu #(.TAG_W(TAG_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .io    (bus)
    );

    always #5 clk = ~clk;

    // Reference behaviour written from the instruction semantics.
    function automatic logic [15:0] model_op(input logic [7:0] a, input logic [7:0] f,
                                             input logic rot, input logic right);
        logic       c;
        logic [7:0] r;
        logic [7:0] nf;
        c  = rot ? f[0] : 1'b0;
        nf = f;
        if (right) begin
            r     = (a >> 1) | {c, 7'b0};
            nf[0] = a[0];
        end else begin
            r     = (a << 1) | {7'b0, c};
            nf[0] = a[7];
        end
        nf[1] = (r == 8'h00);
        nf[7] = r[7];
        return {r, nf};
    endfunction

    // Inputs change only at posedge+1, so the negedge view is what the next edge sees.
    always @(negedge clk) begin
        if (!rst_n || flush) begin
            exp_q.delete();
        end else begin
            if (bus.out_valid && bus.out_ready) begin
                checks++;
                mon_got = {bus.out_tag, bus.out_q, bus.out_f};
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL result_unexpected: got tag/q/f %h, none expected", mon_got);
                end else begin
                    mon_exp = exp_q.pop_front();
                    if (mon_got !== mon_exp)
                        begin
                            errors++;
                            $display("FAIL result_order: got tag/q/f %h, required %h", mon_got, mon_exp);
                        end
                end
            end
            if (bus.in_valid && bus.in_ready)
                exp_q.push_back({bus.in_tag, model_op(bus.in_a, bus.in_f, bus.in_rotate, bus.in_right)});
        end
    end

    task automatic issue(input logic [TAG_W-1:0] tag, input logic [7:0] a, input logic [7:0] f,
                         input logic rot, input logic right);
        int n;
        n = 0;
        bus.in_valid  = 1'b1;
        bus.in_tag    = tag;
        bus.in_a      = a;
        bus.in_f      = f;
        bus.in_rotate = rot;
        bus.in_right  = right;
        while (1) begin
            @(negedge clk);
            if (bus.in_ready) break;
            n++;
            if (n > 50) begin
                checks++;
                errors++;
                $display("FAIL issue_timeout: tag %0d not accepted, in_ready=%b required 1", tag, bus.in_ready);
                break;
            end
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({bus.out_valid, bus.out_tag, bus.out_q, bus.out_f} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got v/tag/q/f %h, required 0",
                     {bus.out_valid, bus.out_tag, bus.out_q, bus.out_f});
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: got in_ready=%b out_valid=%b, required 1 0", bus.in_ready, bus.out_valid);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_asl();
        bus.out_ready = 1'b1;
        issue(4'd3, 8'h0C, 8'h5B, 1'b0, 1'b0);
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL asl_early: got out_valid=%b one edge after issue, required 0", bus.out_valid);
        end
        @(posedge clk); #1;
        checks++;
        if ({bus.out_valid, bus.out_tag, bus.out_q, bus.out_f} !== {1'b1, 4'd3, 8'h18, 8'h58}) begin
            errors++;
            $display("FAIL asl_result: got v/tag/q/f %h, required %h",
                     {bus.out_valid, bus.out_tag, bus.out_q, bus.out_f}, {1'b1, 4'd3, 8'h18, 8'h58});
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        bus.out_ready = 1'b1;
        issue(4'd1, 8'h0C, 8'h5B, 1'b1, 1'b0);
        issue(4'd2, 8'hB3, 8'h5B, 1'b0, 1'b0);
        checks++;
        if ({bus.out_valid, bus.out_tag, bus.out_q, bus.out_f} !== {1'b1, 4'd1, 8'h19, 8'h58}) begin
            errors++;
            $display("FAIL rol_result: got v/tag/q/f %h, required %h",
                     {bus.out_valid, bus.out_tag, bus.out_q, bus.out_f}, {1'b1, 4'd1, 8'h19, 8'h58});
        end
        @(posedge clk); #1;
        checks++;
        if ({bus.out_valid, bus.out_tag, bus.out_q, bus.out_f} !== {1'b1, 4'd2, 8'h66, 8'h59}) begin
            errors++;
            $display("FAIL asl_b2b_result: got v/tag/q/f %h, required %h",
                     {bus.out_valid, bus.out_tag, bus.out_q, bus.out_f}, {1'b1, 4'd2, 8'h66, 8'h59});
        end
        @(posedge clk); #1;
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_drain: got out_valid=%b, required 0", bus.out_valid);
        end
    endtask

    task automatic test_lsr_ror();
        bus.out_ready = 1'b1;
        issue(4'd4, 8'h01, 8'h00, 1'b0, 1'b1);
        issue(4'd5, 8'h01, 8'h01, 1'b1, 1'b1);
        checks++;
        if ({bus.out_valid, bus.out_tag, bus.out_q, bus.out_f} !== {1'b1, 4'd4, 8'h00, 8'h03}) begin
            errors++;
            $display("FAIL lsr_result: got v/tag/q/f %h, required %h",
                     {bus.out_valid, bus.out_tag, bus.out_q, bus.out_f}, {1'b1, 4'd4, 8'h00, 8'h03});
        end
        @(posedge clk); #1;
        checks++;
        if ({bus.out_valid, bus.out_tag, bus.out_q, bus.out_f} !== {1'b1, 4'd5, 8'h80, 8'h81}) begin
            errors++;
            $display("FAIL ror_result: got v/tag/q/f %h, required %h",
                     {bus.out_valid, bus.out_tag, bus.out_q, bus.out_f}, {1'b1, 4'd5, 8'h80, 8'h81});
        end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        logic [EW-1:0] held;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_tag = 4'd1; bus.in_a = 8'h81; bus.in_f = 8'hC4; bus.in_rotate = 1'b1; bus.in_right = 1'b1;
        @(posedge clk); #1;
        bus.in_tag = 4'd2; bus.in_a = 8'h7E; bus.in_f = 8'h3A; bus.in_rotate = 1'b0; bus.in_right = 1'b0;
        @(posedge clk); #1;
        bus.in_tag = 4'd3; bus.in_a = 8'h00; bus.in_f = 8'hFF; bus.in_rotate = 1'b1; bus.in_right = 1'b0;
        checks++;
        if ({bus.in_ready, bus.out_valid, bus.out_tag} !== {1'b0, 1'b1, 4'd1}) begin
            errors++;
            $display("FAIL bp_full: got in_ready/out_valid/tag %h, required %h",
                     {bus.in_ready, bus.out_valid, bus.out_tag}, {1'b0, 1'b1, 4'd1});
        end
        held = {bus.out_tag, bus.out_q, bus.out_f};
        repeat (3) begin
            @(posedge clk); #1;
            checks++;
            if ({bus.in_ready, bus.out_valid, bus.out_tag, bus.out_q, bus.out_f} !== {1'b0, 1'b1, held}) begin
                errors++;
                $display("FAIL bp_stall_hold: got rdy/v/tag/q/f %h, required %h",
                         {bus.in_ready, bus.out_valid, bus.out_tag, bus.out_q, bus.out_f}, {1'b0, 1'b1, held});
            end
        end
        bus.out_ready = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_ready_comb: got in_ready=%b after out_ready rose, required 1", bus.in_ready);
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        checks++;
        if ({bus.out_valid, bus.out_tag} !== {1'b1, 4'd2}) begin
            errors++;
            $display("FAIL bp_second: got v/tag %h, required %h", {bus.out_valid, bus.out_tag}, {1'b1, 4'd2});
        end
        @(posedge clk); #1;
        checks++;
        if ({bus.out_valid, bus.out_tag} !== {1'b1, 4'd3}) begin
            errors++;
            $display("FAIL bp_third: got v/tag %h, required %h", {bus.out_valid, bus.out_tag}, {1'b1, 4'd3});
        end
        @(posedge clk); #1;
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_drain: got out_valid=%b, required 0", bus.out_valid);
        end
    endtask

    task automatic test_flush();
        logic [15:0] m;
        m = model_op(8'h42, 8'h80, 1'b0, 1'b1);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_tag = 4'd5; bus.in_a = 8'h11; bus.in_f = 8'h00; bus.in_rotate = 1'b0; bus.in_right = 1'b0;
        @(posedge clk); #1;
        bus.in_tag = 4'd6; bus.in_a = 8'h22;
        @(posedge clk); #1;
        bus.in_tag = 4'd7; bus.in_a = 8'h42; bus.in_f = 8'h80; bus.in_rotate = 1'b0; bus.in_right = 1'b1;
        flush = 1'b1;
        #1;
        checks++;
        if ({bus.in_ready, bus.out_valid} !== 2'b01) begin
            errors++;
            $display("FAIL flush_cycle: got in_ready/out_valid %b, required 01", {bus.in_ready, bus.out_valid});
        end
        @(posedge clk); #1;
        flush = 1'b0;
        bus.out_ready = 1'b1;
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_squash: got out_valid=%b, required 0", bus.out_valid);
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_refill_early: got out_valid=%b, required 0", bus.out_valid);
        end
        @(posedge clk); #1;
        checks++;
        if ({bus.out_valid, bus.out_tag, bus.out_q, bus.out_f} !== {1'b1, 4'd7, m}) begin
            errors++;
            $display("FAIL flush_refill: got v/tag/q/f %h, required %h",
                     {bus.out_valid, bus.out_tag, bus.out_q, bus.out_f}, {1'b1, 4'd7, m});
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        int   sent;
        int   cyc;
        int   n;
        logic acc;
        sent = 0;
        cyc  = 0;
        bus.in_valid = 1'b0;
        while (sent < 60 && cyc < 3000) begin
            if (!bus.in_valid && $urandom_range(0, 3) != 0) begin
                bus.in_valid  = 1'b1;
                bus.in_tag    = sent[TAG_W-1:0];
                bus.in_a      = 8'($urandom_range(0, 255));
                bus.in_f      = 8'($urandom_range(0, 255));
                bus.in_rotate = 1'($urandom_range(0, 1));
                bus.in_right  = 1'($urandom_range(0, 1));
            end
            bus.out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            acc = bus.in_valid && bus.in_ready;
            @(posedge clk); #1;
            cyc++;
            if (acc) begin
                bus.in_valid = 1'b0;
                sent++;
            end
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (sent != 60 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL random_drain: got sent=%0d pending=%0d, required 60 0", sent, exp_q.size());
        end
    endtask

    task automatic test_reset_mid();
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_tag = 4'd10; bus.in_a = 8'hC3; bus.in_f = 8'h24; bus.in_rotate = 1'b0; bus.in_right = 1'b1;
        @(posedge clk); #1;
        bus.in_tag = 4'd11; bus.in_a = 8'h55;
        @(posedge clk); #1;
        checks++;
        if ({bus.out_valid, bus.out_tag} !== {1'b1, 4'd10}) begin
            errors++;
            $display("FAIL rstmid_before: got v/tag %h, required %h", {bus.out_valid, bus.out_tag}, {1'b1, 4'd10});
        end
        #2;
        rst_n = 1'b0;
        #1;
        bus.in_valid = 1'b0;
        checks++;
        if ({bus.out_valid, bus.out_tag, bus.out_q, bus.out_f} !== '0) begin
            errors++;
            $display("FAIL rstmid_async: got v/tag/q/f %h, required 0",
                     {bus.out_valid, bus.out_tag, bus.out_q, bus.out_f});
        end
        @(negedge clk);
        @(posedge clk); #3;
        rst_n = 1'b1;
        #1;
        checks++;
        if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
            errors++;
            $display("FAIL rstmid_release: got in_ready/out_valid %b, required 10", {bus.in_ready, bus.out_valid});
        end
        @(posedge clk); #1;
        issue(4'd9, 8'h80, 8'h00, 1'b0, 1'b0);
        @(posedge clk); #1;
        checks++;
        if ({bus.out_valid, bus.out_tag, bus.out_q, bus.out_f} !== {1'b1, 4'd9, 8'h00, 8'h03}) begin
            errors++;
            $display("FAIL rstmid_asl80: got v/tag/q/f %h, required %h",
                     {bus.out_valid, bus.out_tag, bus.out_q, bus.out_f}, {1'b1, 4'd9, 8'h00, 8'h03});
        end
        @(posedge clk); #1;
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_tag    = '0;
        bus.in_a      = '0;
        bus.in_f      = '0;
        bus.in_rotate = 1'b0;
        bus.in_right  = 1'b0;
        bus.out_ready = 1'b1;
        test_reset();
        test_asl();
        test_back_to_back();
        test_lsr_ror();
        test_backpressure();
        test_flush();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
